// File: rtl/transaction_engine.sv
// ============================================================================
// Module      : transaction_engine
// Description : Responder side of the start/finished transaction handshake.
//               Reads the key and balances, validates, commits, animates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transaction_engine #(
  parameter int MONEY_WIDTH = 8,
  parameter int KEY_WIDTH   = 4,
  parameter int ANIM_CYCLES = 8,
  localparam int CNT_W      = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_transaction_i,
  input  logic                   direction_i,
  input  logic [MONEY_WIDTH-1:0] amount_i,
  input  logic [KEY_WIDTH-1:0]   key_i,
  input  logic [MONEY_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]             mem_addr_o,
  output logic [MONEY_WIDTH-1:0] mem_wdata_o,
  output logic                   mem_wren_o,
  output logic                   anim_active_o,
  output logic [CNT_W-1:0]       anim_count_o,
  output logic                   finished_transaction_o,
  output logic                   tx_ok_o,
  output logic [1:0]             tx_err_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_KEY   = 4'd1,
    S_RD_SRC   = 4'd2,
    S_RD_DST   = 4'd3,
    S_CHECK    = 4'd4,
    S_EVAL     = 4'd5,
    S_WR_SRC   = 4'd6,
    S_WR_DST   = 4'd7,
    S_ANIMATE  = 4'd8,
    S_DONE     = 4'd9,
    S_WAIT_LOW = 4'd10
  } state_t;

  localparam logic [1:0] c_ERR_NONE = 2'b00;
  localparam logic [1:0] c_ERR_KEY  = 2'b01;
  localparam logic [1:0] c_ERR_FUND = 2'b10;
  localparam logic [1:0] c_ERR_OVF  = 2'b11;
  localparam logic [CNT_W-1:0] c_ANIM_LAST = CNT_W'(ANIM_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   dir_q;
  logic [MONEY_WIDTH-1:0] amt_q;
  logic [KEY_WIDTH-1:0]   key_in_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [MONEY_WIDTH-1:0] src_q;
  logic [MONEY_WIDTH-1:0] dst_q;
  logic [CNT_W-1:0]       anim_cnt_q;
  logic                   tx_ok_q;
  logic [1:0]             tx_err_q;

  logic [MONEY_WIDTH:0]   w_sum;
  logic [MONEY_WIDTH-1:0] w_diff;
  logic [1:0]             w_err;
  logic                   w_anim_last;
  logic                   w_wr;

  assign w_sum       = {1'b0, dst_q} + {1'b0, amt_q};
  assign w_diff      = src_q - amt_q;
  assign w_anim_last = (anim_cnt_q == c_ANIM_LAST);

  // Validation priority: key first, then funds, then receiver overflow.
  always_comb begin
    w_err = c_ERR_NONE;
    if (key_in_q != key_q) begin
      w_err = c_ERR_KEY;
    end else if (amt_q > src_q) begin
      w_err = c_ERR_FUND;
    end else if (w_sum[MONEY_WIDTH]) begin
      w_err = c_ERR_OVF;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_transaction_i) state_d = S_RD_KEY;
      S_RD_KEY:   state_d = S_RD_SRC;
      S_RD_SRC:   state_d = S_RD_DST;
      S_RD_DST:   state_d = S_CHECK;
      S_CHECK:    state_d = S_EVAL;
      S_EVAL:     state_d = (w_err != c_ERR_NONE) ? S_DONE : S_WR_SRC;
      S_WR_SRC:   state_d = S_WR_DST;
      S_WR_DST:   state_d = S_ANIMATE;
      S_ANIMATE:  if (w_anim_last) state_d = S_DONE;
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!start_transaction_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      dir_q      <= 1'b0;
      amt_q      <= '0;
      key_in_q   <= '0;
      key_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      anim_cnt_q <= '0;
      tx_ok_q    <= 1'b0;
      tx_err_q   <= c_ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_transaction_i) begin
            dir_q    <= direction_i;
            amt_q    <= amount_i;
            key_in_q <= key_i;
            tx_ok_q  <= 1'b0;
            tx_err_q <= c_ERR_NONE;
          end
        end
        // RAM data lags the address by one cycle, so each capture
        // happens in the state after the one that issued the read.
        S_RD_SRC: key_q <= mem_rdata_i[KEY_WIDTH-1:0];
        S_RD_DST: src_q <= mem_rdata_i;
        S_CHECK:  dst_q <= mem_rdata_i;
        S_EVAL: begin
          if (w_err != c_ERR_NONE) begin
            tx_ok_q  <= 1'b0;
            tx_err_q <= w_err;
          end
        end
        S_ANIMATE: begin
          if (w_anim_last) begin
            anim_cnt_q <= '0;
            tx_ok_q    <= 1'b1;
            tx_err_q   <= c_ERR_NONE;
          end else begin
            anim_cnt_q <= anim_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr_o             = 2'b00;
    mem_wdata_o            = '0;
    w_wr                   = 1'b0;
    anim_active_o          = 1'b0;
    anim_count_o           = '0;
    finished_transaction_o = 1'b0;
    case (state_q)
      S_RD_KEY: mem_addr_o = {1'b1, dir_q};
      S_RD_SRC: mem_addr_o = {1'b0, dir_q};
      S_RD_DST: mem_addr_o = {1'b0, ~dir_q};
      S_WR_SRC: begin
        mem_addr_o  = {1'b0, dir_q};
        mem_wdata_o = w_diff;
        w_wr        = 1'b1;
      end
      S_WR_DST: begin
        mem_addr_o  = {1'b0, ~dir_q};
        mem_wdata_o = w_sum[MONEY_WIDTH-1:0];
        w_wr        = 1'b1;
      end
      S_ANIMATE: begin
        anim_active_o = 1'b1;
        anim_count_o  = anim_cnt_q;
      end
      S_DONE: finished_transaction_o = 1'b1;
      default: ;
    endcase
  end

  // A reset landing on a write cycle must not corrupt the RAM.
  assign mem_wren_o = w_wr & ~reset_i;
  assign tx_ok_o    = tx_ok_q;
  assign tx_err_o   = tx_err_q;

endmodule

`default_nettype wire

// File: tb/tb_transaction_engine.sv
// ============================================================================
// Module      : tb_transaction_engine
// Description : Directed bench for transaction_engine with a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_transaction_engine;
  localparam int MW = 8;
  localparam int KW = 4;
  localparam int N  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          direction;
  logic [MW-1:0] amount;
  logic [KW-1:0] key;
  logic [MW-1:0] mem_rdata;
  logic [1:0]    mem_addr;
  logic [MW-1:0] mem_wdata;
  logic          mem_wren;
  logic          anim_active;
  logic [CW-1:0] anim_count;
  logic          finished;
  logic          tx_ok;
  logic [1:0]    tx_err;

  always #5 clk = ~clk;

  transaction_engine #(.MONEY_WIDTH(MW), .KEY_WIDTH(KW), .ANIM_CYCLES(N)) dut (
    .clock_i(clk), .reset_i(reset), .start_transaction_i(start),
    .direction_i(direction), .amount_i(amount), .key_i(key),
    .mem_rdata_i(mem_rdata), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_wren_o(mem_wren), .anim_active_o(anim_active), .anim_count_o(anim_count),
    .finished_transaction_o(finished), .tx_ok_o(tx_ok), .tx_err_o(tx_err)
  );

  // Shared balance RAM: synchronous read, one cycle latency.
  logic [MW-1:0] ram [4];
  logic [MW-1:0] ld_val [4];
  logic          ld = 1'b0;
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 4; i++) ram[i] <= ld_val[i];
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] exp_ram [4];
  logic          e_ok;
  logic [1:0]    e_err;
  logic          e_s;
  logic [MW-1:0] e_src_new, e_dst_new;
  int            e_fin;
  logic          trk_on = 1'b0;
  int            k;
  int            fin_at;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic load_ram(input int p1, input int p2, input int k1, input int k2);
    ld_val[0] = MW'(p1); ld_val[1] = MW'(p2); ld_val[2] = MW'(k1); ld_val[3] = MW'(k2);
    for (int i = 0; i < 4; i++) exp_ram[i] = ld_val[i];
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Outcome of a transfer straight from the rules: key, funds, overflow.
  task automatic model(input logic dir, input logic [MW-1:0] amt, input logic [KW-1:0] ky);
    int src, dst, kw;
    e_s = dir;
    kw  = int'(exp_ram[{1'b1, dir}]) % (1 << KW);
    src = int'(exp_ram[{1'b0, dir}]);
    dst = int'(exp_ram[{1'b0, ~dir}]);
    if (int'(ky) != kw)                 e_err = 2'b01;
    else if (int'(amt) > src)           e_err = 2'b10;
    else if (dst + int'(amt) > 255)     e_err = 2'b11;
    else                                e_err = 2'b00;
    e_ok      = (e_err == 2'b00);
    e_fin     = e_ok ? 8 + N : 6;
    e_src_new = MW'(src - int'(amt));
    e_dst_new = MW'(dst + int'(amt));
  endtask

  function automatic logic [18:0] expect_vec(input int c);
    logic          wren = 1'b0;
    logic [1:0]    addr = 2'b00;
    logic [MW-1:0] wd   = '0;
    logic          act  = 1'b0;
    logic [CW-1:0] cnt  = '0;
    logic          fin;
    logic          tok  = 1'b0;
    logic [1:0]    terr = 2'b00;
    if (c == 1) addr = {1'b1, e_s};
    if (c == 2) addr = {1'b0, e_s};
    if (c == 3) addr = {1'b0, ~e_s};
    if (e_ok && c == 6) begin addr = {1'b0, e_s};  wd = e_src_new; wren = 1'b1; end
    if (e_ok && c == 7) begin addr = {1'b0, ~e_s}; wd = e_dst_new; wren = 1'b1; end
    if (e_ok && c >= 8 && c < 8 + N) begin act = 1'b1; cnt = CW'(c - 8); end
    fin = (c == e_fin);
    if (c >= e_fin) begin tok = e_ok; terr = e_err; end
    return {wren, addr, wd, act, cnt, fin, tok, terr};
  endfunction

  task automatic check_cycle();
    logic [18:0] act, exp, mask;
    act  = {mem_wren, mem_addr, mem_wdata, anim_active, anim_count, finished, tx_ok, tx_err};
    exp  = expect_vec(k);
    mask = (k == 0) ? 19'h7FFF8 : 19'h7FFFF;
    checks++;
    if ((act & mask) != (exp & mask)) begin
      errors++;
      $display("FAIL cycle[%0d] outputs got %h want %h", k, act & mask, exp & mask);
    end
    if (finished && fin_at < 0) fin_at = k;
    k++;
  endtask

  task automatic tick();
    @(negedge clk);
    if (trk_on) check_cycle();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic dir, input logic [MW-1:0] amt,
                         input logic [KW-1:0] ky, input int hold);
    model(dir, amt, ky);
    direction = dir; amount = amt; key = ky; start = 1'b1;
    trk_on = 1'b1; k = 0; fin_at = -1;
    tick();
    direction = ~dir; amount = ~amt; key = ~ky;
    for (int i = 0; i < 40 && fin_at < 0; i++) tick();
    if (fin_at < 0) begin
      errors++;
      $display("FAIL finish_timeout got none want cycle %0d", e_fin);
    end
    for (int i = 0; i < hold; i++) tick();
    start = 1'b0; trk_on = 1'b0;
    tick();
    if (e_ok) begin
      exp_ram[{1'b0, dir}]  = e_src_new;
      exp_ram[{1'b0, ~dir}] = e_dst_new;
    end
    chk("ram_p1", int'(ram[0]), int'(exp_ram[0]));
    chk("ram_p2", int'(ram[1]), int'(exp_ram[1]));
  endtask

  task automatic run_reset(input logic dir, input logic [MW-1:0] amt,
                           input logic [KW-1:0] ky, input int rk);
    model(dir, amt, ky);
    direction = dir; amount = amt; key = ky; start = 1'b1;
    repeat (rk) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wren", int'(mem_wren), 0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_outs", int'({mem_wren, mem_addr, mem_wdata, anim_active, anim_count,
                          finished, tx_ok, tx_err}), 0);
    repeat (3) begin @(posedge clk); #1; end
    if (e_ok && rk >= 8) begin
      exp_ram[{1'b0, dir}]  = e_src_new;
      exp_ram[{1'b0, ~dir}] = e_dst_new;
    end
    chk("rst_ram_p1", int'(ram[0]), int'(exp_ram[0]));
    chk("rst_ram_p2", int'(ram[1]), int'(exp_ram[1]));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; direction = 1'b0; amount = '0; key = '0;
    for (int i = 0; i < 4; i++) ld_val[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outs", int'({mem_wren, mem_addr, mem_wdata, anim_active, anim_count,
                            finished, tx_ok, tx_err}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: basic P1 -> P2 transfer
    load_ram(100, 50, 5, 0);
    run_txn(1'b0, 8'd30, 4'd5, 1);
    chk("t1_p1", int'(ram[0]), 70);
    chk("t1_p2", int'(ram[1]), 80);
    chk("t1_latency", fin_at, 16);
    chk("t1_ok", int'(tx_ok), 1);

    // 2: wrong key
    load_ram(100, 50, 5, 0);
    run_txn(1'b0, 8'd30, 4'd6, 1);
    chk("t2_latency", fin_at, 6);
    chk("t2_err", int'(tx_err), 1);
    chk("t2_p1", int'(ram[0]), 100);

    // 3: funds, overflow, priority
    load_ram(100, 50, 5, 0);
    run_txn(1'b0, 8'd101, 4'd5, 1);
    chk("t3_funds", int'(tx_err), 2);
    load_ram(100, 250, 5, 0);
    run_txn(1'b0, 8'd10, 4'd5, 1);
    chk("t3_ovf", int'(tx_err), 3);
    run_txn(1'b0, 8'd101, 4'd6, 1);
    chk("t3_prio", int'(tx_err), 1);

    // Boundaries: exact funds, sum landing on 255, sum hitting 256
    load_ram(60, 215, 3, 0);
    run_txn(1'b0, 8'd40, 4'd3, 1);
    chk("b_max_p2", int'(ram[1]), 255);
    load_ram(40, 216, 3, 0);
    run_txn(1'b0, 8'd40, 4'd3, 1);
    chk("b_ovf", int'(tx_err), 3);
    load_ram(40, 10, 3, 0);
    run_txn(1'b0, 8'd40, 4'd3, 1);
    chk("b_exact_p1", int'(ram[0]), 0);

    // 4: P2 pays P1, held start, then re-trigger
    load_ram(100, 50, 5, 9);
    run_txn(1'b1, 8'd50, 4'd9, 5);
    chk("t4_p2", int'(ram[1]), 0);
    chk("t4_p1", int'(ram[0]), 150);
    run_txn(1'b0, 8'd20, 4'd5, 1);
    chk("t4b_p1", int'(ram[0]), 130);

    // 5: reset in WR_SRC, then in ANIMATE
    load_ram(100, 50, 5, 0);
    run_reset(1'b0, 8'd30, 4'd5, 6);
    chk("t5_p1", int'(ram[0]), 100);
    run_reset(1'b0, 8'd30, 4'd5, 10);
    run_txn(1'b0, 8'd10, 4'd5, 1);
    chk("t5_ok", int'(tx_ok), 1);

    // 6: zero amount
    load_ram(100, 50, 5, 0);
    run_txn(1'b0, 8'd0, 4'd5, 1);
    chk("t6_latency", fin_at, 8 + N);
    chk("t6_ok", int'(tx_ok), 1);
    chk("t6_p1", int'(ram[0]), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
